// File: rtl/ffn_pkg.sv
// Shared definitions for the FFN stream loader.
//   - default width constants used as parameter defaults
//   - loader state type
//   - bit-offset helpers for the flat vector / matrix packing
package ffn_pkg;

   localparam int DEF_DATA_WIDTH = 16;
   localparam int DEF_ACC_WIDTH  = 64;
   localparam int DEF_NEURON_NUM = 4;
   localparam int DEF_LAYER_W    = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD_D,
      ST_LOAD_W,
      ST_RUN,
      ST_WAIT,
      ST_DRAIN
   } ffn_ld_state_t;

   // LSB of element i in a flat vector of w-bit elements
   function automatic int vec_lsb(input int i, input int w);
      return i * w;
   endfunction

   // LSB of element [r][c] in a flat row-major n x n matrix of w-bit elements
   function automatic int mat_lsb(input int r, input int c, input int n, input int w);
      return (r * n + c) * w;
   endfunction

endpackage

// File: rtl/ffn_act_sat.sv
// Inter-layer activation for one neuron: saturates a signed accumulator to
// the signed data range. With FFN_LOADER_RELU_EN defined, negative results
// are additionally clamped to zero.
// Ports:
//   acc_i  signed ACC_WIDTH accumulator
//   act_o  signed DATA_WIDTH activation
module ffn_act_sat
   import ffn_pkg::*;
#(
   parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic signed [ACC_WIDTH-1:0]  acc_i,
   output logic signed [DATA_WIDTH-1:0] act_o
);

   localparam logic signed [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   logic                         fits;
   logic signed [DATA_WIDTH-1:0] sat;

   // value fits when every bit above the data sign bit copies the acc sign
   assign fits = (acc_i[ACC_WIDTH-1:DATA_WIDTH-1] == {(ACC_WIDTH-DATA_WIDTH+1){acc_i[ACC_WIDTH-1]}});

   always_comb begin
      sat = acc_i[DATA_WIDTH-1:0];
      if (!fits) sat = acc_i[ACC_WIDTH-1] ? SAT_MIN : SAT_MAX;
      act_o = sat;
`ifdef FFN_LOADER_RELU_EN
      if (sat[DATA_WIDTH-1]) act_o = '0;
`endif
   end

endmodule

// File: rtl/ffn_stream_loader.sv
// Streams data and weights into local buffers, launches the FFN core, chains
// activated results into the next layer and streams the final accumulators
// out. Optional macro FFN_LOADER_RELU_EN adds ReLU to the inter-layer
// activation (final outputs are always raw accumulators).
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   start_i, layers_i         run request and layer count (0 means 1)
//   s_valid_i/s_ready_o/s_data_i   input element stream
//   core_data_o/core_weight_o/core_start_o/core_done_i/core_acc_i   core side
//   m_valid_o/m_ready_i/m_data_o/m_last_o   output element stream
//   busy_o, done_o            status
//
// state    | meaning
// ---------+-----------------------------------------------
// IDLE     | waiting for start_i
// LOAD_D   | accepting N data beats
// LOAD_W   | accepting N*N weight beats, row-major
// RUN      | core_start_o high for this single cycle
// WAIT     | waiting for core_done_i, then chain or drain
// DRAIN    | streaming N accumulators out
module ffn_stream_loader
   import ffn_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
   parameter int NEURON_NUM = DEF_NEURON_NUM,
   parameter int LAYER_W    = DEF_LAYER_W
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic                                     start_i,
   input  logic [LAYER_W-1:0]                       layers_i,
   input  logic                                     s_valid_i,
   output logic                                     s_ready_o,
   input  logic [DATA_WIDTH-1:0]                    s_data_i,
   output logic [DATA_WIDTH*NEURON_NUM-1:0]         core_data_o,
   output logic [DATA_WIDTH*NEURON_NUM*NEURON_NUM-1:0] core_weight_o,
   output logic                                     core_start_o,
   input  logic                                     core_done_i,
   input  logic [ACC_WIDTH*NEURON_NUM-1:0]          core_acc_i,
   output logic                                     m_valid_o,
   input  logic                                     m_ready_i,
   output logic [ACC_WIDTH-1:0]                     m_data_o,
   output logic                                     m_last_o,
   output logic                                     busy_o,
   output logic                                     done_o
);

   localparam int N   = NEURON_NUM;
   localparam int DW  = DATA_WIDTH;
   localparam int AW  = ACC_WIDTH;
   localparam int DIW = (N > 1) ? $clog2(N) : 1;
   localparam int CW  = (N * N > 1) ? $clog2(N * N) : 1;
   localparam logic [DIW-1:0] D_LAST = DIW'(N - 1);
   localparam logic [CW-1:0]  W_LAST = CW'(N * N - 1);

   ffn_ld_state_t        state;
   logic [CW-1:0]        beat_cnt;
   logic [DIW-1:0]       out_idx;
   logic [DIW-1:0]       out_idx_nxt;
   logic [LAYER_W-1:0]   layers_q;
   logic [LAYER_W-1:0]   layer_cnt;
   logic                 s_fire;

   logic signed [DW-1:0] data_buf   [N];
   logic signed [DW-1:0] weight_buf [N*N];
   logic signed [DW-1:0] act_val    [N];
   logic signed [AW-1:0] acc_buf    [N];

   assign s_fire      = s_valid_i & s_ready_o;
   assign out_idx_nxt = out_idx + 1'b1;

   for (genvar r = 0; r < N; r++) begin : g_row
      ffn_act_sat #(.ACC_WIDTH(AW), .DATA_WIDTH(DW)) u_act (
         .acc_i (core_acc_i[vec_lsb(r, AW) +: AW]),
         .act_o (act_val[r])
      );
      assign core_data_o[vec_lsb(r, DW) +: DW] = data_buf[r];
      for (genvar c = 0; c < N; c++) begin : g_col
         assign core_weight_o[mat_lsb(r, c, N, DW) +: DW] = weight_buf[r*N + c];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         beat_cnt     <= '0;
         out_idx      <= '0;
         layers_q     <= '0;
         layer_cnt    <= '0;
         s_ready_o    <= 1'b0;
         core_start_o <= 1'b0;
         m_valid_o    <= 1'b0;
         m_data_o     <= '0;
         m_last_o     <= 1'b0;
         busy_o       <= 1'b0;
         done_o       <= 1'b0;
         for (int i = 0; i < N; i++) begin
            data_buf[i] <= '0;
            acc_buf[i]  <= '0;
         end
         for (int i = 0; i < N * N; i++) weight_buf[i] <= '0;
      end else begin
         core_start_o <= 1'b0;
         done_o       <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start_i) begin
                  layers_q  <= (layers_i == '0) ? LAYER_W'(1) : layers_i;
                  layer_cnt <= '0;
                  beat_cnt  <= '0;
                  s_ready_o <= 1'b1;
                  busy_o    <= 1'b1;
                  state     <= ST_LOAD_D;
               end
            end
            ST_LOAD_D: begin
               if (s_fire) begin
                  data_buf[beat_cnt[DIW-1:0]] <= s_data_i;
                  if (beat_cnt[DIW-1:0] == D_LAST) begin
                     beat_cnt <= '0;
                     state    <= ST_LOAD_W;
                  end else begin
                     beat_cnt <= beat_cnt + 1'b1;
                  end
               end
            end
            ST_LOAD_W: begin
               if (s_fire) begin
                  weight_buf[beat_cnt] <= s_data_i;
                  if (beat_cnt == W_LAST) begin
                     beat_cnt     <= '0;
                     s_ready_o    <= 1'b0;
                     core_start_o <= 1'b1;
                     state        <= ST_RUN;
                  end else begin
                     beat_cnt <= beat_cnt + 1'b1;
                  end
               end
            end
            ST_RUN: begin
               state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (core_done_i) begin
                  for (int r = 0; r < N; r++) acc_buf[r] <= core_acc_i[r*AW +: AW];
                  if (layer_cnt != layers_q - 1'b1) begin
                     // chain: activated results become the next layer's data,
                     // only the weights are re-streamed
                     layer_cnt <= layer_cnt + 1'b1;
                     for (int r = 0; r < N; r++) data_buf[r] <= act_val[r];
                     s_ready_o <= 1'b1;
                     state     <= ST_LOAD_W;
                  end else begin
                     out_idx   <= '0;
                     m_data_o  <= core_acc_i[0 +: AW];
                     m_valid_o <= 1'b1;
                     m_last_o  <= (D_LAST == DIW'(0));
                     state     <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               if (m_valid_o && m_ready_i) begin
                  if (out_idx == D_LAST) begin
                     m_valid_o <= 1'b0;
                     m_last_o  <= 1'b0;
                     done_o    <= 1'b1;
                     busy_o    <= 1'b0;
                     state     <= ST_IDLE;
                  end else begin
                     out_idx  <= out_idx_nxt;
                     m_data_o <= acc_buf[out_idx_nxt];
                     m_last_o <= (out_idx_nxt == D_LAST);
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ffn_stream_loader.sv
module tb_ffn_stream_loader;

   localparam int N  = 4;
   localparam int DW = 16;
   localparam int AW = 64;
   localparam int LW = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              start_i;
   logic [LW-1:0]     layers_i;
   logic              s_valid_i;
   logic              s_ready_o;
   logic [DW-1:0]     s_data_i;
   logic [DW*N-1:0]   core_data_o;
   logic [DW*N*N-1:0] core_weight_o;
   logic              core_start_o;
   logic              core_done_i;
   logic [AW*N-1:0]   core_acc_i;
   logic              m_valid_o;
   logic              m_ready_i;
   logic [AW-1:0]     m_data_o;
   logic              m_last_o;
   logic              busy_o;
   logic              done_o;

   ffn_stream_loader dut (
      .clk(clk), .rst(rst), .start_i(start_i), .layers_i(layers_i),
      .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_data_i(s_data_i),
      .core_data_o(core_data_o), .core_weight_o(core_weight_o),
      .core_start_o(core_start_o), .core_done_i(core_done_i), .core_acc_i(core_acc_i),
      .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_data_o(m_data_o),
      .m_last_o(m_last_o), .busy_o(busy_o), .done_o(done_o)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   longint rd [N];
   longint rw [4][N*N];
   longint exp_out [N];
   longint in_q [$];

   // ---------------- core model: acc[r] = sum_c w[r][c]*d[c], done ~5 cycles after start
   logic            model_done;
   logic            spur_done;
   logic [AW*N-1:0] model_acc;
   int              dly;

   assign core_done_i = model_done | spur_done;
   assign core_acc_i  = model_acc;

   function automatic logic [AW*N-1:0] core_compute();
      logic [AW*N-1:0] v;
      longint s, d, w;
      v = '0;
      for (int r = 0; r < N; r++) begin
         s = 0;
         for (int c = 0; c < N; c++) begin
            d = longint'($signed(core_data_o[c*DW +: DW]));
            w = longint'($signed(core_weight_o[(r*N+c)*DW +: DW]));
            s = s + d * w;
         end
         v[r*AW +: AW] = s;
      end
      return v;
   endfunction

   always @(negedge clk) begin
      if (rst) begin
         dly        <= 0;
         model_done <= 1'b0;
         model_acc  <= '0;
      end else begin
         model_done <= 1'b0;
         if (core_start_o) begin
            model_acc <= core_compute();
            dly       <= 5;
         end else if (dly > 1) begin
            dly <= dly - 1;
         end else if (dly == 1) begin
            dly        <= 0;
            model_done <= 1'b1;
         end
      end
   end

   // ---------------- reference model: layer arithmetic from the rules
   function automatic longint act(input longint x);
      longint y;
      y = (x > 32767) ? 64'sd32767 : ((x < -32768) ? -64'sd32768 : x);
`ifdef FFN_LOADER_RELU_EN
      if (y < 0) y = 0;
`endif
      return y;
   endfunction

   task automatic ref_model(input int nl);
      longint d [N];
      longint acc [N];
      for (int i = 0; i < N; i++) d[i] = rd[i];
      for (int l = 0; l < nl; l++) begin
         for (int r = 0; r < N; r++) begin
            acc[r] = 0;
            for (int c = 0; c < N; c++) acc[r] = acc[r] + rw[l][r*N+c] * d[c];
         end
         for (int r = 0; r < N; r++) begin
            if (l < nl - 1) d[r] = act(acc[r]);
            else exp_out[r] = acc[r];
         end
      end
   endtask

   task automatic set_diag(input int l, input longint v);
      for (int k = 0; k < N*N; k++) rw[l][k] = ((k / N) == (k % N)) ? v : 0;
   endtask

   task automatic set_data(input longint a, input longint b, input longint c, input longint d);
      rd[0] = a; rd[1] = b; rd[2] = c; rd[3] = d;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ---------------- stimulus helpers (all start and end just after a negedge)
   task automatic stream(input int n, input bit vrand, input int spur_at);
      int guard;
      longint v;
      for (int i = 0; i < n; i++) begin
         if (vrand) begin
            s_valid_i = 1'b0;
            while ($urandom_range(1, 0) == 0) @(negedge clk);
         end
         v = in_q.pop_front();
         s_valid_i = 1'b1;
         s_data_i  = v[DW-1:0];
         if (i == spur_at) begin
            start_i   = 1'b1;
            spur_done = 1'b1;
         end
         guard = 0;
         while (!s_ready_o && guard < 100) begin
            @(negedge clk);
            guard++;
         end
         chk("s_ready_wait", s_ready_o, 1);
         @(negedge clk);
         start_i   = 1'b0;
         spur_done = 1'b0;
      end
      s_valid_i = 1'b0;
   endtask

   task automatic begin_run(input int lay);
      layers_i = LW'(lay);
      start_i  = 1'b1;
      @(negedge clk);
      start_i  = 1'b0;
      chk("busy_after_start", busy_o, 1);
      chk("ready_after_start", s_ready_o, 1);
   endtask

   task automatic drain(input int mode);
      int guard, idx, ph;
      bit rdy, hold_chk;
      logic [AW-1:0] held;
      guard = 0; idx = 0; ph = 0; hold_chk = 0; held = '0;
      m_ready_i = 1'b0;
      while (!m_valid_o && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      chk("m_valid_wait", m_valid_o, 1);
      while (idx < N && guard < 300) begin
         case (mode)
            0:       rdy = 1'b1;
            1:       rdy = (ph % 4 == 0) || (ph % 4 == 3);
            default: rdy = 1'($urandom_range(1, 0));
         endcase
         m_ready_i = rdy;
         chk("m_valid", m_valid_o, 1);
         chk("m_data", m_data_o, exp_out[idx]);
         chk("m_last", m_last_o, (idx == N - 1));
         chk("busy_drain", busy_o, 1);
         if (hold_chk) chk("m_data_hold", m_data_o, held);
         hold_chk = !rdy;
         held = m_data_o;
         if (rdy) idx++;
         ph++;
         guard++;
         @(negedge clk);
      end
      m_ready_i = 1'b0;
      chk("done_pulse", done_o, 1);
      chk("busy_end", busy_o, 0);
      chk("m_valid_end", m_valid_o, 0);
      @(negedge clk);
      chk("done_clear", done_o, 0);
   endtask

   task automatic run_full(input int lay_in, input int nl, input bit vrand,
                           input int rmode, input int spur_at);
      ref_model(nl);
      begin_run(lay_in);
      for (int l = 0; l < nl; l++) begin
         in_q.delete();
         if (l == 0) for (int i = 0; i < N; i++) in_q.push_back(rd[i]);
         for (int k = 0; k < N*N; k++) in_q.push_back(rw[l][k]);
         stream(in_q.size(), vrand, (l == 0) ? spur_at : -1);
         chk("core_start", core_start_o, 1);
         chk("ready_low_run", s_ready_o, 0);
         @(negedge clk);
         chk("core_start_once", core_start_o, 0);
      end
      drain(rmode);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; start_i = 1'b0; layers_i = '0; s_valid_i = 1'b0;
      s_data_i = '0; m_ready_i = 1'b0; spur_done = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_s_ready", s_ready_o, 0);
      chk("rst_core_start", core_start_o, 0);
      chk("rst_m_valid", m_valid_o, 0);
      chk("rst_m_last", m_last_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_m_data", m_data_o, 0);
      rst = 1'b0;
      @(negedge clk);

      // single layer, identity
      set_data(1, 2, 3, 4); set_diag(0, 1);
      run_full(1, 1, 0, 0, -1);

      // two-layer chaining with 2*I
      set_data(1, -2, 3, -4); set_diag(0, 2); set_diag(1, 2);
      run_full(2, 2, 0, 0, -1);

      // saturation up and down
      set_data(300, 300, 300, 300); set_diag(0, 300); set_diag(1, 1);
      run_full(2, 2, 0, 0, -1);
      set_diag(0, -300);
      run_full(2, 2, 0, 0, -1);

      // backpressure on both streams
      set_data(1, 2, 3, 4); set_diag(0, 1);
      run_full(1, 1, 1, 1, -1);

      // reset after 7 weight beats
      begin_run(1);
      in_q.delete();
      for (int i = 0; i < N; i++) in_q.push_back(rd[i]);
      for (int k = 0; k < 7; k++) in_q.push_back(rw[0][k]);
      stream(N + 7, 0, -1);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_s_ready", s_ready_o, 0);
      chk("abort_busy", busy_o, 0);
      chk("abort_m_valid", m_valid_o, 0);
      rst = 1'b0;
      @(negedge clk);
      set_data(5, -6, 7, -8);
      run_full(0, 1, 0, 0, -1);

      // spurious start/done inside LOAD_W
      set_data(1, 2, 3, 4); set_diag(0, 1);
      run_full(1, 1, 0, 0, N + 5);

      // randomized runs
      for (int t = 0; t < 4; t++) begin
         int nl;
         nl = int'($urandom_range(3, 1));
         for (int i = 0; i < N; i++) rd[i] = longint'($urandom_range(400, 0)) - 200;
         for (int l = 0; l < nl; l++)
            for (int k = 0; k < N*N; k++) rw[l][k] = longint'($urandom_range(100, 0)) - 50;
         run_full(nl, nl, 1, 2, -1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ffn_stream_loader.md
Name: ffn_stream_loader

Overview:
- Parametrised successor to the fixed 4x4 FFN wrapper.
- Accepts data and weights as a valid/ready element stream and buffers them into an N-entry data array and an NxN weight array.
- Launches the FFN systolic core, captures its N accumulators, and chains results into the next layer's input for multi-layer runs.
- After the final layer, streams results out with valid/ready.

Parameters:
- DATA_WIDTH, 16, width of data/weight elements (signed)
- ACC_WIDTH, 64, width of each core accumulator (signed)
- NEURON_NUM, 4, N; data vector length and weight matrix dimension
- LAYER_W, 4, width of layer-count input

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- start_i  in  1  begin a run; sampled only in IDLE
- layers_i  in  LAYER_W  number of layers; latched on start; 0 treated as 1
- s_valid_i  in  1  input element valid
- s_ready_o  out  1  input element accepted when s_valid_i & s_ready_o
- s_data_i  in  DATA_WIDTH  input element (signed)
- core_data_o  out  DATA_WIDTH*N  data vector; element i at [i*DW +: DW]
- core_weight_o  out  DATA_WIDTH*N*N  weight[r][c] at [(r*N+c)*DW +: DW]
- core_start_o  out  1  one-cycle launch pulse to core
- core_done_i  in  1  core result valid (single-cycle pulse)
- core_acc_i  in  ACC_WIDTH*N  accumulator r at [r*AW +: AW]
- m_valid_o  out  1  output element valid
- m_ready_i  in  1  output accept
- m_data_o  out  ACC_WIDTH  output element (final-layer accumulator)
- m_last_o  out  1  high with final output element
- busy_o  out  1  high whenever state != IDLE
- done_o  out  1  one-cycle pulse after last output accepted

Behaviour:
- Reset values: s_ready_o, core_start_o, m_valid_o, m_last_o, busy_o, done_o = 0; m_data_o = 0. State = IDLE; counters = 0. Buffer contents are unspecified but must not reach outputs before being rewritten.
- States: IDLE, LOAD_D, LOAD_W, RUN, WAIT, DRAIN.
- IDLE: on start_i, latch layers (0 -> 1), clear layer_cnt, go to LOAD_D. start_i is ignored in all other states.
- LOAD_D: s_ready_o = 1. Accept N beats into data[0..N-1] in order. After beat N-1 is accepted, go to LOAD_W.
- LOAD_W: s_ready_o = 1. Accept N*N beats row-major (beat k -> weight[k/N][k%N]). After the last beat, go to RUN.
- s_ready_o = 0 in every state other than LOAD_D and LOAD_W.
- RUN: core_start_o = 1 for exactly one cycle, which is the cycle after the last weight beat. Then go to WAIT.
- WAIT: on core_done_i, register core_acc_i into the result buffer.
  - If layer_cnt < layers-1: increment layer_cnt; data[r] <= act(acc[r]); go to LOAD_W (weights only; data is not re-streamed).
  - Otherwise go to DRAIN.
  - core_done_i in any state other than WAIT is ignored.
- act(x): saturate signed ACC_WIDTH to signed DATA_WIDTH range [-2^(DW-1), 2^(DW-1)-1], plus ReLU when the optional feature is enabled.
- DRAIN: m_valid_o asserts the cycle after capture. m_data_o = acc[idx], idx from 0 to N-1, advancing only on m_valid_o & m_ready_i. m_data_o holds stable while m_ready_i is low. m_last_o = (idx == N-1).
- After the last beat is accepted: done_o pulses for 1 cycle and the FSM returns to IDLE in the same cycle; busy_o drops that cycle.
- core_data_o and core_weight_o are driven from registers and are stable from RUN through WAIT.
- rst asserted in any state aborts the run: outputs take their reset values next cycle and partial counts are discarded.

Optional Feature:
- Macro: FFN_LOADER_RELU_EN.
- Defined: inter-layer act() clamps negative values to 0 after saturation.
- Undefined: act() is saturation only.
- The final-layer outputs on m_data_o are always the raw accumulators in both cases.

Decomposition:
- Package ffn_pkg holds:
  - state enum typedef ffn_ld_state_t
  - default width constants
  - index helper functions for the flat packing
- Sub-module ffn_act_sat: one instance per neuron; combinational saturate (+optional ReLU) from ACC_WIDTH to DATA_WIDTH.

Test Plan:
- Bench core model: acc[r] = sum_c w[r][c]*d[c], done 5 cycles after start. Parameters N=4, DW=16, AW=64.
1. Single layer: layers=1, data {1,2,3,4}, W=identity -> m_data 1,2,3,4; m_last on 4th beat; done_o 1 cycle later; core_start_o exactly 1 cycle after beat 20.
2. Two-layer chaining: layers=2, data {1,-2,3,-4}, W=2*I both layers -> layer-1 acc {2,-4,6,-8}. Without macro output {4,-8,12,-16}; with FFN_LOADER_RELU_EN output {4,0,12,0}. Only 16 beats accepted for layer 2.
3. Saturation: layers=2, data {300,300,300,300}, W=I*300 then W=I -> chained data 32767 each; output 32767 x4. With negative weight -300: -32768 without ReLU.
4. Backpressure: s_valid_i random 50% duty and m_ready_i toggling 1-0-0-1 -> identical results to test 1; m_data_o stable while m_ready_i=0.
5. Reset mid-load: rst after 7 weight beats -> s_ready_o=0 and busy_o=0 next cycle. A new run with layers=0 behaves as 1 layer and yields the correct results.
6. Spurious inputs: start_i and core_done_i pulsed during LOAD_W -> ignored; beat count and results unchanged.
